// File: rtl/conv_kxk_stream_mac.sv
// Streaming KxK convolution MAC: sliding column window, 3-stage multiply/sum/requantise pipeline.
// Optional saturation statistics counter built only when STREAM_MAC_STATS_EN is defined.
module conv_kxk_stream_mac #(
  parameter int K     = 3,
  parameter int IMG_W = 8,
  parameter int WGT_W = 4,
  parameter int ACC_W = 17,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5,
  parameter int ZP_W  = 9
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [K*IMG_W-1:0]     in_pix,
  input  logic [K*WGT_W-1:0]     in_wgt,
  input  logic [SH_W-1:0]        q_shift,
  input  logic [ZP_W-1:0]        zero_point,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_conv,
  output logic                   out_last,
  output logic                   out_sat,
  output logic [15:0]            sat_count
);

  localparam int N  = K * K;
  localparam int PW = IMG_W + WGT_W + 1;
  localparam int FW = $clog2(K);
  localparam int M1 = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int M2 = (M1 > ZP_W) ? M1 : ZP_W;
  localparam int RW = M2 + 2;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic stall, accept, complete;
  logic [FW-1:0] fill_cnt;

  // window[c][r]: column 0 is the oldest, column K-1 the newest
  logic        [IMG_W-1:0] win_pix [K][K];
  logic signed [WGT_W-1:0] win_wgt [K][K];

  logic                   v0, v1, v2;
  logic                   last0, last1, last2;
  logic [SH_W-1:0]        q0, q1, q2;
  logic signed [ZP_W-1:0] zp0, zp1, zp2;
  logic signed [PW-1:0]   prod_c [N];
  logic signed [PW-1:0]   prod1  [N];
  logic signed [ACC_W-1:0] acc_c, acc2;

  logic signed [RW-1:0] ext, rnd, shf, sum3;
  logic [OUT_W-1:0]     res_c;
  logic                 sat_c;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign complete = accept && (fill_cnt == FW'(K-1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fill_cnt  <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_conv  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        if (in_last)
          fill_cnt <= '0;
        else if (fill_cnt != FW'(K-1))
          fill_cnt <= fill_cnt + FW'(1);
      end
      v0        <= complete;
      v1        <= v0;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_conv <= res_c;
        out_last <= last2;
        out_sat  <= sat_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      if (accept) begin
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c + 1 < K; c++) begin
            win_pix[c][r] <= win_pix[c+1][r];
            win_wgt[c][r] <= win_wgt[c+1][r];
          end
          win_pix[K-1][r] <= in_pix[r*IMG_W +: IMG_W];
          win_wgt[K-1][r] <= in_wgt[r*WGT_W +: WGT_W];
        end
      end
      if (complete) begin
        last0 <= in_last;
        q0    <= q_shift;
        zp0   <= zero_point;
      end
      prod1 <= prod_c;
      last1 <= last0;
      q1    <= q0;
      zp1   <= zp0;
      acc2  <= acc_c;
      last2 <= last1;
      q2    <= q1;
      zp2   <= zp1;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < K; c++)
      for (int unsigned r = 0; r < K; r++)
        prod_c[c*K+r] = $signed({1'b0, win_pix[c][r]}) * win_wgt[c][r];
  end

  always_comb begin
    acc_c = '0;
    for (int unsigned i = 0; i < N; i++)
      acc_c = acc_c + ACC_W'(prod1[i]);
  end

  // widened so rounding bias and zero point cannot wrap before saturation
  always_comb begin
    ext   = RW'(acc2);
    rnd   = (q2 != '0) ? (RW'(1) <<< (q2 - SH_W'(1))) : '0;
    shf   = (ext + rnd) >>> q2;
    sum3  = shf + RW'(zp2);
    sat_c = 1'b0;
    res_c = sum3[OUT_W-1:0];
    if (sum3 > MAXV) begin
      res_c = MAXV[OUT_W-1:0];
      sat_c = 1'b1;
    end else if (sum3 < MINV) begin
      res_c = MINV[OUT_W-1:0];
      sat_c = 1'b1;
    end
  end

`ifdef STREAM_MAC_STATS_EN
  logic [15:0] sat_cnt_q;
  always_ff @(posedge clk) begin
    if (!rstn)
      sat_cnt_q <= '0;
    else if (out_valid && out_ready && out_sat)
      sat_cnt_q <= sat_cnt_q + 16'd1;
  end
  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule
